// File: rtl/gost_pkg.sv
// Shared types and widths for the GOST byte-serial front end.
package gost_pkg;

    localparam int KEY_W     = 256;
    localparam int BLK_W     = 64;
    localparam int KEY_CNT_W = 5;
    localparam int BLK_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_UNLOAD = 2'd2
    } state_e;

endpackage

// File: rtl/gost_byte_shreg.sv
// Parallel-load register that shifts a byte in at the LSB end and keeps a byte
// counter which either saturates at CNT_MAX or wraps from CNT_MAX back to 0.
module gost_byte_shreg #(
    parameter int W        = 64,
    parameter int CNT_W    = 4,
    parameter int CNT_MAX  = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [W-1:0]     load_val,
    input  logic             shift,
    input  logic [7:0]       byte_in,
    input  logic             cnt_clr,
    output logic [W-1:0]     q,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [W-1:0]     data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (load) begin
            data_d = load_val;
            cnt_d  = '0;
        end else if (shift) begin
            data_d = {data_q[W-9:0], byte_in};
            if (cnt_q == CNT_TOP) begin
                cnt_d = SATURATE ? cnt_q : '0;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
        if (cnt_clr) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (en) begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign q   = data_q;
    assign cnt = cnt_q;

endmodule

// File: rtl/gost_byte_io.sv
// Byte-serial front end: collects key and block bytes from pins, launches the
// GOST round core, and streams its 64-bit result back out MSB byte first.
module gost_byte_io
    import gost_pkg::*;
#(
    parameter int KEY_BYTES = KEY_W / 8,
    parameter int BLK_BYTES = BLK_W / 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic [7:0]             in_byte,
    input  logic                   in_valid,
    input  logic                   in_sel,
    input  logic                   mode,
    input  logic                   start,
    input  logic                   out_next,
    output logic [KEY_BYTES*8-1:0] core_key,
    output logic [BLK_BYTES*8-1:0] core_block,
    output logic                   core_decrypt,
    output logic                   core_start,
    input  logic                   core_done,
    input  logic [BLK_BYTES*8-1:0] core_result,
    output logic [7:0]             out_byte,
    output logic                   out_valid,
    output logic                   busy,
    output logic                   blk_ready
);

    localparam int KW     = KEY_BYTES * 8;
    localparam int BW     = BLK_BYTES * 8;
    localparam int KEY_CW = $clog2(KEY_BYTES);
    localparam int BLK_CW = $clog2(BLK_BYTES + 1);
    localparam logic [BLK_CW-1:0] BLK_FULL = BLK_CW'(BLK_BYTES);
    localparam logic [BLK_CW-1:0] BLK_LAST = BLK_CW'(BLK_BYTES - 1);

    state_e state_q, state_d;
    logic   mode_q, mode_d;
    logic   core_start_q, core_start_d;

    logic [KEY_CW-1:0] key_cnt;
    logic [BLK_CW-1:0] blk_cnt;
    logic [BLK_CW-1:0] out_cnt;
    logic [BW-1:0]     out_sr;
    logic              unused_bits;

    logic in_load, key_shift, blk_shift, start_ok;
    logic out_load, out_shift, last_out;

    // Writes and start are only honoured in LOAD; blk_ready reflects the
    // pre-write count, so a write in the same cycle as start cannot enable it.
    assign in_load   = (state_q == ST_LOAD);
    assign key_shift = in_load && in_valid && in_sel;
    assign blk_shift = in_load && in_valid && !in_sel;
    assign blk_ready = (blk_cnt == BLK_FULL);
    assign start_ok  = in_load && start && blk_ready;
    assign out_load  = (state_q == ST_RUN) && core_done;
    assign out_shift = (state_q == ST_UNLOAD) && out_next;
    assign last_out  = out_shift && (out_cnt == BLK_LAST);

    gost_byte_shreg #(.W(KW), .CNT_W(KEY_CW), .CNT_MAX(KEY_BYTES - 1), .SATURATE(1'b0)) u_key (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (ena),
        .load     (1'b0),
        .load_val ('0),
        .shift    (key_shift),
        .byte_in  (in_byte),
        .cnt_clr  (1'b0),
        .q        (core_key),
        .cnt      (key_cnt)
    );

    gost_byte_shreg #(.W(BW), .CNT_W(BLK_CW), .CNT_MAX(BLK_BYTES), .SATURATE(1'b1)) u_blk (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (ena),
        .load     (1'b0),
        .load_val ('0),
        .shift    (blk_shift),
        .byte_in  (in_byte),
        .cnt_clr  (last_out),
        .q        (core_block),
        .cnt      (blk_cnt)
    );

    gost_byte_shreg #(.W(BW), .CNT_W(BLK_CW), .CNT_MAX(BLK_BYTES), .SATURATE(1'b1)) u_out (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (ena),
        .load     (out_load),
        .load_val (core_result),
        .shift    (out_shift),
        .byte_in  (8'h00),
        .cnt_clr  (1'b0),
        .q        (out_sr),
        .cnt      (out_cnt)
    );

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        core_start_d = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (start_ok) begin
                    mode_d       = mode;
                    core_start_d = 1'b1;
                    state_d      = ST_RUN;
                end
            end
            ST_RUN: begin
                if (core_done) begin
                    state_d = ST_UNLOAD;
                end
            end
            ST_UNLOAD: begin
                if (last_out) begin
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_LOAD;
            mode_q       <= 1'b0;
            core_start_q <= 1'b0;
        end else if (ena) begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            core_start_q <= core_start_d;
        end
    end

    assign core_start   = core_start_q;
    assign core_decrypt = mode_q;
    assign busy         = (state_q == ST_RUN);
    assign out_valid    = (state_q == ST_UNLOAD);
    assign out_byte     = out_valid ? out_sr[BW-1 -: 8] : 8'h00;

    // Only the top byte of the result register and none of the key count feed logic.
    assign unused_bits = ^{out_sr[BW-9:0], key_cnt};

endmodule

// File: tb/tb_gost_byte_io.sv
// Self-checking bench for gost_byte_io with a behavioural core stub and a
// byte-queue reference model of the key/block/result paths.
module tb_gost_byte_io;

    localparam logic [255:0] KEY1 =
        256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ena = 1'b1;
    logic [7:0]   in_byte = 8'h00;
    logic         in_valid = 1'b0;
    logic         in_sel = 1'b0;
    logic         mode = 1'b0;
    logic         start = 1'b0;
    logic         out_next = 1'b0;
    logic [255:0] core_key;
    logic [63:0]  core_block;
    logic         core_decrypt;
    logic         core_start;
    logic         core_done;
    logic [63:0]  core_result;
    logic [7:0]   out_byte;
    logic         out_valid;
    logic         busy;
    logic         blk_ready;

    int checks = 0;
    int failures = 0;
    int start_pulses = 0;

    logic [7:0] mkey[$];
    logic [7:0] mblk[$];
    int         mblk_cnt = 0;

    int   stub_cnt;
    logic stub_done;
    logic man_done = 1'b0;

    assign core_done = stub_done | man_done;

    gost_byte_io dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .in_byte      (in_byte),
        .in_valid     (in_valid),
        .in_sel       (in_sel),
        .mode         (mode),
        .start        (start),
        .out_next     (out_next),
        .core_key     (core_key),
        .core_block   (core_block),
        .core_decrypt (core_decrypt),
        .core_start   (core_start),
        .core_done    (core_done),
        .core_result  (core_result),
        .out_byte     (out_byte),
        .out_valid    (out_valid),
        .busy         (busy),
        .blk_ready    (blk_ready)
    );

    always #5 clk = ~clk;

    // Core stub: inverts the block, answers a few cycles after the launch pulse.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_cnt    <= 0;
            stub_done   <= 1'b0;
            core_result <= 64'h0;
        end else begin
            stub_done <= 1'b0;
            if (stub_cnt == 1) begin
                stub_done   <= 1'b1;
                core_result <= core_block ^ ONES;
            end
            if (stub_cnt > 0) stub_cnt <= stub_cnt - 1;
            if (core_start) stub_cnt <= 4;
        end
    end

    always @(posedge clk) if (core_start) start_pulses++;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] m_key();
        logic [255:0] a = '0;
        foreach (mkey[i]) a = (a << 8) | 256'(mkey[i]);
        return a;
    endfunction

    function automatic logic [63:0] m_blk();
        logic [63:0] a = '0;
        foreach (mblk[i]) a = (a << 8) | 64'(mblk[i]);
        return a;
    endfunction

    function automatic void m_write(input logic sel, input logic [7:0] b);
        if (sel) begin
            mkey.push_back(b);
            if (mkey.size() > 32) void'(mkey.pop_front());
        end else begin
            mblk.push_back(b);
            if (mblk.size() > 8) void'(mblk.pop_front());
            if (mblk_cnt < 8) mblk_cnt++;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic sel, input logic [7:0] b, input logic en);
        ena = en; in_valid = 1'b1; in_sel = sel; in_byte = b;
        tick();
        in_valid = 1'b0; ena = 1'b1;
        if (en) m_write(sel, b);
    endtask

    task automatic poke_with_start(input logic sel, input logic [7:0] b);
        in_valid = 1'b1; in_sel = sel; in_byte = b; start = 1'b1;
        tick();
        in_valid = 1'b0; start = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        mkey.delete(); mblk.delete(); mblk_cnt = 0;
    endtask

    // Launches one block (optionally with a same-cycle write) and drains the result.
    task automatic run_block(input logic m, input bit inject, input bit wr_with, input logic [7:0] wb);
        int base = start_pulses;
        int n = 0;
        logic [63:0] exp_res;
        mode = m; start = 1'b1;
        if (wr_with) begin in_valid = 1'b1; in_sel = 1'b0; in_byte = wb; end
        tick();
        start = 1'b0; in_valid = 1'b0; mode = 1'b0;
        if (wr_with) m_write(1'b0, wb);
        chk("busy_after_start", busy, 1'b1);
        chk("core_start_pulse", core_start, 1'b1);
        chk("core_decrypt", core_decrypt, m);
        chk("core_key", core_key, m_key());
        chk("core_block", core_block, m_blk());
        if (inject) begin
            poke_with_start(1'b0, 8'hEE);
            poke_with_start(1'b1, 8'hDD);
            chk("block_held_run", core_block, m_blk());
            chk("key_held_run", core_key, m_key());
        end
        while (!core_done && n < 20) begin tick(); n++; end
        chk("core_done_seen", core_done, 1'b1);
        chk("no_valid_before_done", out_valid, 1'b0);
        chk("decrypt_held", core_decrypt, m);
        tick();
        chk("valid_one_cycle", out_valid, 1'b1);
        exp_res = m_blk() ^ ONES;
        for (int i = 0; i < 8; i++) begin
            chk("out_byte", out_byte, exp_res[63 - 8*i -: 8]);
            chk("out_valid_hold", out_valid, 1'b1);
            if (inject && i == 3) poke_with_start(1'b0, 8'h77);
            if (inject && i == 5) begin
                ena = 1'b0; out_next = 1'b1;
                tick();
                ena = 1'b1; out_next = 1'b0;
                chk("out_byte_ena0", out_byte, exp_res[63 - 8*i -: 8]);
            end
            out_next = 1'b1;
            tick();
            out_next = 1'b0;
        end
        mblk_cnt = 0;
        chk("valid_cleared", out_valid, 1'b0);
        chk("ready_cleared", blk_ready, 1'b0);
        chk("busy_cleared", busy, 1'b0);
        chk("block_after", core_block, m_blk());
        chk("single_start", start_pulses - base, 1);
    endtask

    typedef struct {
        int          nbytes;
        logic [7:0]  first;
        logic        m;
        bit          inject;
        logic [63:0] exp_blk;
    } vec_t;

    vec_t tbl[3];

    initial begin
        tbl[0] = '{10, 8'h11, 1'b0, 1'b0, 64'h131415161718191A};
        tbl[1] = '{8,  8'hA0, 1'b1, 1'b1, 64'hA0A1A2A3A4A5A6A7};
        tbl[2] = '{12, 8'hF8, 1'b0, 1'b0, 64'hFCFDFEFF00010203};

        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_core_start", core_start, 1'b0);
        do_reset();
        chk("rst_key", core_key, 256'h0);
        chk("rst_block", core_block, 64'h0);
        chk("rst_decrypt", core_decrypt, 1'b0);
        chk("rst_out_byte", out_byte, 8'h00);
        chk("rst_ready", blk_ready, 1'b0);

        for (int i = 0; i < 32; i++) wr(1'b1, 8'(i), 1'b1);
        for (int i = 1; i <= 8; i++) wr(1'b0, 8'(i), 1'b1);
        chk("key_first", core_key, KEY1);
        chk("block_first", core_block, 64'h0102030405060708);
        chk("ready_first", blk_ready, 1'b1);
        run_block(1'b0, 1'b0, 1'b0, 8'h00);

        foreach (tbl[t]) begin
            for (int k = 0; k < tbl[t].nbytes; k++) wr(1'b0, 8'(tbl[t].first + 8'(k)), 1'b1);
            chk("tbl_block", core_block, {192'h0, tbl[t].exp_blk});
            chk("tbl_key_reused", core_key, KEY1);
            run_block(tbl[t].m, tbl[t].inject, 1'b0, 8'h00);
        end

        for (int k = 0; k < 5; k++) wr(1'b0, 8'(8'h21 + 8'(k)), 1'b1);
        start = 1'b1; tick(); start = 1'b0;
        chk("short_no_busy", busy, 1'b0);
        chk("short_no_pulse", core_start, 1'b0);
        for (int k = 5; k < 7; k++) wr(1'b0, 8'(8'h21 + 8'(k)), 1'b1);
        poke_with_start(1'b0, 8'h28);
        m_write(1'b0, 8'h28);
        chk("prewrite_start_ignored", busy, 1'b0);
        chk("ready_after_8", blk_ready, 1'b1);
        wr(1'b0, 8'h55, 1'b0);
        chk("ena0_block_frozen", core_block, m_blk());
        ena = 1'b0; start = 1'b1; tick(); start = 1'b0; ena = 1'b1;
        chk("ena0_start_lost", busy, 1'b0);
        run_block(1'b1, 1'b0, 1'b1, 8'h29);

        for (int it = 0; it < 25; it++) begin
            int nk = $urandom_range(0, 3);
            int nb = $urandom_range(0, 10);
            for (int k = 0; k < nk; k++) wr(1'b1, 8'($urandom), ($urandom_range(0, 3) != 0));
            for (int k = 0; k < nb; k++) wr(1'b0, 8'($urandom), ($urandom_range(0, 3) != 0));
            chk("rnd_key", core_key, m_key());
            chk("rnd_block", core_block, m_blk());
            chk("rnd_ready", blk_ready, mblk_cnt == 8);
            if (mblk_cnt == 8) begin
                run_block(1'($urandom_range(0, 1)), 1'b0, 1'b0, 8'h00);
            end else begin
                start = 1'b1; tick(); start = 1'b0;
                chk("rnd_start_ignored", busy, 1'b0);
            end
        end

        for (int k = 0; k < 8; k++) wr(1'b0, 8'(8'h60 + 8'(k)), 1'b1);
        start = 1'b1; tick(); start = 1'b0;
        chk("pre_reset_busy", busy, 1'b1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_block", core_block, 64'h0);
        chk("async_rst_key", core_key, 256'h0);
        tick();
        rst_n = 1'b1;
        mkey.delete(); mblk.delete(); mblk_cnt = 0;
        man_done = 1'b1; tick(); man_done = 1'b0;
        chk("late_done_valid", out_valid, 1'b0);
        chk("late_done_busy", busy, 1'b0);
        tick();
        chk("late_done_valid2", out_valid, 1'b0);
        chk("late_done_byte", out_byte, 8'h00);
        chk("late_done_start", core_start, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
